// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_gen_pkg: segment encoding, default 640x480 timing and segment helpers
package vga_timing_gen_pkg;
  typedef enum logic [2:0] {
    SEG_DISP,
    SEG_BORD1,
    SEG_FP,
    SEG_SYNC,
    SEG_BORD2,
    SEG_BP
  } seg_e;
  localparam int DEF_CW      = 10;
  localparam int DEF_H_DISP  = 640;
  localparam int DEF_H_BORD1 = 8;
  localparam int DEF_H_FP    = 8;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BORD2 = 40;
  localparam int DEF_H_BP    = 8;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_BORD1 = 8;
  localparam int DEF_V_FP    = 2;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BORD2 = 25;
  localparam int DEF_V_BP    = 8;
  // Display or either border: the area framed by BORDER.
  function automatic logic in_area(seg_e s);
    return s == SEG_DISP || s == SEG_BORD1 || s == SEG_BORD2;
  endfunction
endpackage

// File: rtl/vga_timing_gen_axis_timer.sv
// vga_timing_gen_axis_timer: one raster axis (counter, segment FSM, sync level)
//   clk_i, rst_ni : clock, synchronous active-low reset
//   step_i        : advance the counter by one
//   count_o       : registered position, 0..TOTAL-1
//   seg_o         : segment the counter enters on the coming edge
//   sync_o        : registered sync level, POL while in the sync segment
//   wrap_o        : counter is at TOTAL-1, the next step wraps to 0
module vga_timing_gen_axis_timer
  import vga_timing_gen_pkg::*;
#(
  parameter int   CW    = 10,
  parameter int   DISP  = 640,
  parameter int   BORD1 = 8,
  parameter int   FP    = 8,
  parameter int   SYNC  = 96,
  parameter int   BORD2 = 40,
  parameter int   BP    = 8,
  parameter logic POL   = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          step_i,
  output logic [CW-1:0] count_o,
  output seg_e          seg_o,
  output logic          sync_o,
  output logic          wrap_o
);
  // Last count of each segment; an empty border shares its predecessor's last count.
  localparam logic [CW-1:0] L_DISP = CW'(DISP - 1);
  localparam logic [CW-1:0] L_B1   = CW'(DISP + BORD1 - 1);
  localparam logic [CW-1:0] L_FP   = CW'(DISP + BORD1 + FP - 1);
  localparam logic [CW-1:0] L_SY   = CW'(DISP + BORD1 + FP + SYNC - 1);
  localparam logic [CW-1:0] L_B2   = CW'(DISP + BORD1 + FP + SYNC + BORD2 - 1);
  localparam logic [CW-1:0] L_BP   = CW'(DISP + BORD1 + FP + SYNC + BORD2 + BP - 1);
  logic [CW-1:0] count_q, count_d;
  seg_e          seg_q, seg_d;
  logic          sync_q;
  assign wrap_o  = count_q == L_BP;
  assign count_d = step_i ? (wrap_o ? '0 : count_q + CW'(1)) : count_q;
  always_comb begin
    seg_d = seg_q;
    if (step_i)
      case (seg_q)
        SEG_DISP:  if (count_q == L_DISP) seg_d = (BORD1 > 0) ? SEG_BORD1 : SEG_FP;
        SEG_BORD1: if (count_q == L_B1)   seg_d = SEG_FP;
        SEG_FP:    if (count_q == L_FP)   seg_d = SEG_SYNC;
        SEG_SYNC:  if (count_q == L_SY)   seg_d = (BORD2 > 0) ? SEG_BORD2 : SEG_BP;
        SEG_BORD2: if (count_q == L_B2)   seg_d = SEG_BP;
        SEG_BP:    if (wrap_o)            seg_d = SEG_DISP;
        default:                          seg_d = SEG_BP;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= L_BP;
      seg_q   <= SEG_BP;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      seg_q   <= seg_d;
      sync_q  <= (seg_d == SEG_SYNC) ? POL : ~POL;
    end
  end
  assign count_o = count_q;
  assign seg_o   = seg_d;
  assign sync_o  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (sync, coordinates, enables, strobes)
//   clk_i, rst_ni       : clock, synchronous active-low reset
//   pix_en_i            : pixel tick, raster advances one pixel when 1
//   vga_hs_o, vga_vs_o  : sync outputs, active level HS_POL/VS_POL
//   hcount_o, vcount_o  : current pixel and line
//   de_o, border_o      : display enable, border flag
//   line_start_o        : one-cycle pulse when hcount has just become 0
//   frame_start_o       : one-cycle pulse when (hcount,vcount) has just become (0,0)
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   CW      = DEF_CW,
  parameter int   H_DISP  = DEF_H_DISP,
  parameter int   H_BORD1 = DEF_H_BORD1,
  parameter int   H_FP    = DEF_H_FP,
  parameter int   H_SYNC  = DEF_H_SYNC,
  parameter int   H_BORD2 = DEF_H_BORD2,
  parameter int   H_BP    = DEF_H_BP,
  parameter int   V_DISP  = DEF_V_DISP,
  parameter int   V_BORD1 = DEF_V_BORD1,
  parameter int   V_FP    = DEF_V_FP,
  parameter int   V_SYNC  = DEF_V_SYNC,
  parameter int   V_BORD2 = DEF_V_BORD2,
  parameter int   V_BP    = DEF_V_BP,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          pix_en_i,
  output logic          vga_hs_o,
  output logic          vga_vs_o,
  output logic [CW-1:0] hcount_o,
  output logic [CW-1:0] vcount_o,
  output logic          de_o,
  output logic          border_o,
  output logic          line_start_o,
  output logic          frame_start_o
);
  seg_e h_seg, v_seg;
  logic h_wrap, v_wrap, v_step;
  logic de_q, border_q, line_start_q, frame_start_q;
  logic de_d, border_d, line_start_d, frame_start_d;
  assign v_step = pix_en_i & h_wrap;
  vga_timing_gen_axis_timer #(
    .CW(CW), .DISP(H_DISP), .BORD1(H_BORD1), .FP(H_FP),
    .SYNC(H_SYNC), .BORD2(H_BORD2), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(pix_en_i),
    .count_o(hcount_o), .seg_o(h_seg), .sync_o(vga_hs_o), .wrap_o(h_wrap)
  );
  vga_timing_gen_axis_timer #(
    .CW(CW), .DISP(V_DISP), .BORD1(V_BORD1), .FP(V_FP),
    .SYNC(V_SYNC), .BORD2(V_BORD2), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .clk_i(clk_i), .rst_ni(rst_ni), .step_i(v_step),
    .count_o(vcount_o), .seg_o(v_seg), .sync_o(vga_vs_o), .wrap_o(v_wrap)
  );
  // Flags are decoded from the segments being entered so they line up with the counters.
  assign de_d          = h_seg == SEG_DISP && v_seg == SEG_DISP;
  assign border_d      = in_area(h_seg) && in_area(v_seg) && !de_d;
  assign line_start_d  = v_step;
  assign frame_start_d = v_step & v_wrap;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      de_q          <= 1'b0;
      border_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      border_q      <= border_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign de_o          = de_q;
  assign border_o      = border_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: table, sequence and random checks of a small and a default raster
module tb_vga_timing_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] h, v;
  logic       hs, vs, de, bd, ls, fs;
  logic [9:0] h2, v2;
  logic       hs2, vs2, de2, bd2, ls2, fs2;
  int n_cmp = 0;
  int n_bad = 0;
  int mh = 6, mv = 6;
  logic mls = 1'b0, mfs = 1'b0;
  int dh = 799, dv = 524;
  logic dls = 1'b0, dfs = 1'b0;
  always #5 clk = ~clk;
  vga_timing_gen #(
    .CW(4), .H_DISP(1), .H_BORD1(1), .H_FP(1), .H_SYNC(2), .H_BORD2(1), .H_BP(1),
    .V_DISP(2), .V_BORD1(1), .V_FP(1), .V_SYNC(1), .V_BORD2(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(en), .vga_hs_o(hs), .vga_vs_o(vs),
    .hcount_o(h), .vcount_o(v), .de_o(de), .border_o(bd),
    .line_start_o(ls), .frame_start_o(fs)
  );
  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(en), .vga_hs_o(hs2), .vga_vs_o(vs2),
    .hcount_o(h2), .vcount_o(v2), .de_o(de2), .border_o(bd2),
    .line_start_o(ls2), .frame_start_o(fs2)
  );
  typedef struct packed {
    logic        r;
    logic        e;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[16];
  function automatic logic [13:0] small_now();
    return {h, v, hs, vs, de, bd, ls, fs};
  endfunction
  // Reference raster from segment sums: H 1,1,1,2,1,1 and V 2,1,1,1,1,1, active-low syncs.
  function automatic logic [13:0] small_exp();
    logic e_de, in_h, in_v;
    e_de = mh < 1 && mv < 2;
    in_h = mh < 2 || mh == 5;
    in_v = mv < 3 || mv == 5;
    return {4'(mh), 4'(mv), !(mh >= 3 && mh < 5), mv != 4, e_de, in_h && in_v && !e_de, mls, mfs};
  endfunction
  function automatic logic [25:0] big_exp();
    logic e_de, in_h, in_v;
    e_de = dh < 640 && dv < 480;
    in_h = dh < 648 || (dh >= 752 && dh < 792);
    in_v = dv < 488 || (dv >= 492 && dv < 517);
    return {10'(dh), 10'(dv), dh >= 656 && dh < 752, dv >= 490 && dv < 492,
            e_de, in_h && in_v && !e_de, dls, dfs};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick(input logic r, input logic e);
    rst_n = r;
    en = e;
    @(posedge clk);
    #1;
    if (!r) begin
      mh = 6; mv = 6; mls = 0; mfs = 0;
      dh = 799; dv = 524; dls = 0; dfs = 0;
    end else if (e) begin
      mh = (mh + 1) % 7;
      if (mh == 0) mv = (mv + 1) % 7;
      mls = mh == 0;
      mfs = mh == 0 && mv == 0;
      dh = (dh + 1) % 800;
      if (dh == 0) dv = (dv + 1) % 525;
      dls = dh == 0;
      dfs = dh == 0 && dv == 0;
    end else begin
      mls = 0; mfs = 0; dls = 0; dfs = 0;
    end
  endtask
  initial begin
    int vs_low, de_cnt, ls_cnt, fs_cnt, hs_hi, last_ls, found;
    tbl[0]  = {1'b0, 1'b1, 4'd6, 4'd6, 6'b110000};
    tbl[1]  = {1'b0, 1'b0, 4'd6, 4'd6, 6'b110000};
    tbl[2]  = {1'b0, 1'b1, 4'd6, 4'd6, 6'b110000};
    tbl[3]  = {1'b1, 1'b1, 4'd0, 4'd0, 6'b111011};
    tbl[4]  = {1'b1, 1'b0, 4'd0, 4'd0, 6'b111000};
    tbl[5]  = {1'b1, 1'b0, 4'd0, 4'd0, 6'b111000};
    tbl[6]  = {1'b1, 1'b1, 4'd1, 4'd0, 6'b110100};
    tbl[7]  = {1'b1, 1'b1, 4'd2, 4'd0, 6'b110000};
    tbl[8]  = {1'b1, 1'b1, 4'd3, 4'd0, 6'b010000};
    tbl[9]  = {1'b1, 1'b0, 4'd3, 4'd0, 6'b010000};
    tbl[10] = {1'b1, 1'b1, 4'd4, 4'd0, 6'b010000};
    tbl[11] = {1'b1, 1'b1, 4'd5, 4'd0, 6'b110100};
    tbl[12] = {1'b1, 1'b1, 4'd6, 4'd0, 6'b110000};
    tbl[13] = {1'b1, 1'b1, 4'd0, 4'd1, 6'b111010};
    tbl[14] = {1'b1, 1'b0, 4'd0, 4'd1, 6'b111000};
    tbl[15] = {1'b1, 1'b1, 4'd1, 4'd1, 6'b110100};
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].r, tbl[i].e);
      chk($sformatf("table[%0d]", i), 32'(small_now()), 32'(tbl[i].exp));
    end
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1'b1, 1'b1);
      found = (mh == 3 && mv == 4) ? 1 : 0;
    end
    chk("seek_3_4", found, 1);
    chk("at_3_4", 32'(small_now()), 32'({4'd3, 4'd4, 6'b000000}));
    tick(1'b0, 1'b1);
    chk("midframe_reset", 32'(small_now()), 32'({4'd6, 4'd6, 6'b110000}));
    tick(1'b1, 1'b1);
    chk("restart_00", 32'(small_now()), 32'({4'd0, 4'd0, 6'b111011}));
    vs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 1; i <= 49; i++) begin
      tick(1'b1, 1'b1);
      vs_low += (vs == 1'b0) ? 1 : 0;
      de_cnt += de ? 1 : 0;
      ls_cnt += ls ? 1 : 0;
      fs_cnt += fs ? 1 : 0;
      if (i % 7 == 0) chk($sformatf("line_start_at_%0d", i), 32'(ls), 1);
    end
    chk("frame_vs_low", vs_low, 7);
    chk("frame_de", de_cnt, 2);
    chk("frame_line_starts", ls_cnt, 7);
    chk("frame_fs_at_49", 32'(fs), 1);
    chk("frame_starts", fs_cnt, 1);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom % 64) != 0, ($urandom % 4) != 0);
      chk("random", 32'(small_now()), 32'(small_exp()));
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("def_reset", 32'({h2, v2, hs2, vs2, de2, bd2, ls2, fs2}), 32'({10'd799, 10'd524, 6'b000000}));
    hs_hi = 0;
    last_ls = -1;
    for (int i = 0; i < 1700; i++) begin
      tick(1'b1, 1'b1);
      chk("default", 32'({h2, v2, hs2, vs2, de2, bd2, ls2, fs2}), 32'(big_exp()));
      if (i < 1600) hs_hi += hs2 ? 1 : 0;
      if (ls2) begin
        if (last_ls >= 0) chk("def_line_period", i - last_ls, 800);
        last_ls = i;
      end
    end
    chk("def_hs_high", hs_hi, 192);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
